// File: rtl/seg7_scan_driver.sv
// Self-timed 4-digit 7-segment scan driver with frame-coherent latching, blink and dp masks.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
  parameter int SCAN_DIV       = 100000,
  parameter int BLINK_DIV      = 25000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic [15:0] num,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  anode,
  output logic [7:0]  eSeg,
  output logic        frame_tick
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [1:0]         idx;
  logic [15:0]        frame;
  logic               blink_phase;
  logic               load_pending;

  logic               scan_tc;
  logic               blink_tc;
  logic               load;
  logic [3:0]         cur_digit;
  logic [6:0]         pattern;
  logic [7:0]         seg_on;
  logic [7:0]         eseg_next;
  logic               lz_blank;
  logic               blank;
  logic [3:0]         anode_next;

  assign scan_tc  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign blink_tc = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
  // A new frame is taken only at the end of digit 3 so a digit never shows a half-updated value
  assign load     = (scan_tc && (idx == 2'd3)) || load_pending;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      scan_cnt     <= '0;
      idx          <= '0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      frame        <= '0;
      load_pending <= 1'b1;
      frame_tick   <= 1'b0;
    end else begin
      scan_cnt     <= scan_tc ? '0 : scan_cnt + SCAN_W'(1);
      blink_cnt    <= blink_tc ? '0 : blink_cnt + BLINK_W'(1);
      if (scan_tc)
        idx <= idx + 2'd1;
      if (blink_tc)
        blink_phase <= ~blink_phase;
      if (load) begin
        frame        <= num;
        load_pending <= 1'b0;
      end
      frame_tick <= load;
    end
  end

  always_comb begin
    cur_digit = frame[{idx, 2'b00} +: 4];
    pattern   = 7'b0000000;
    case (cur_digit)
      4'd0:    pattern = 7'b0111111;
      4'd1:    pattern = 7'b0000110;
      4'd2:    pattern = 7'b1011011;
      4'd3:    pattern = 7'b1001111;
      4'd4:    pattern = 7'b1100110;
      4'd5:    pattern = 7'b1101101;
      4'd6:    pattern = 7'b1111101;
      4'd7:    pattern = 7'b0000111;
      4'd8:    pattern = 7'b1111111;
      4'd9:    pattern = 7'b1101111;
      default: pattern = 7'b0000000;
    endcase
    seg_on    = {dp_mask[idx], pattern};
    eseg_next = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
  end

  always_comb begin
    lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (idx)
      2'd3:    lz_blank = (frame[15:12] == 4'h0);
      2'd2:    lz_blank = (frame[15:8]  == 8'h00);
      2'd1:    lz_blank = (frame[15:4]  == 12'h000);
      default: lz_blank = 1'b0;
    endcase
`endif
    blank      = !en || (blink_mask[idx] && blink_phase) || lz_blank;
    anode_next = blank ? 4'b1111 : ~(4'b0001 << idx);
  end

  // Registered outputs keep the anode one-hot-low (or all high) with no decode glitches
  always_ff @(posedge clk) begin
    if (!resetn) begin
      anode <= 4'b1111;
      eSeg  <= SEG_OFF;
    end else begin
      anode <= anode_next;
      eSeg  <= eseg_next;
    end
  end

endmodule
